// File: rtl/pdu_pkg.sv
// Shared types and constants for the pdu_v2 debug unit: FSM states, IO map,
// display sources, button indices and the hex-to-seven-segment decoder.
package pdu_pkg;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [15:0] IO_LED = 16'h0000;
    localparam logic [15:0] IO_SW  = 16'h0004;
    localparam logic [15:0] IO_SEG = 16'h0008;
    localparam logic [15:0] IO_BTN = 16'h000C;

    localparam logic [2:0] SRC_DISP  = 3'd0;
    localparam logic [2:0] SRC_IF_PC = 3'd1;
    localparam logic [2:0] SRC_ID_PC = 3'd2;
    localparam logic [2:0] SRC_DATA  = 3'd3;
    localparam logic [2:0] SRC_BP    = 3'd4;

    // Bit positions inside the packed button vectors, matching {U,D,R,C,L}.
    localparam int BTN_L = 0;
    localparam int BTN_C = 1;
    localparam int BTN_R = 2;
    localparam int BTN_D = 3;
    localparam int BTN_U = 4;

    // Active-low segments, bit 0 = ca ... bit 6 = cg.
    function automatic logic [6:0] hex2seg(input logic [3:0] hex);
        logic [6:0] code;
        code = 7'b1111111;
        unique case (hex)
            4'h0: code = 7'b1000000;
            4'h1: code = 7'b1111001;
            4'h2: code = 7'b0100100;
            4'h3: code = 7'b0110000;
            4'h4: code = 7'b0011001;
            4'h5: code = 7'b0010010;
            4'h6: code = 7'b0000010;
            4'h7: code = 7'b1111000;
            4'h8: code = 7'b0000000;
            4'h9: code = 7'b0010000;
            4'hA: code = 7'b0001000;
            4'hB: code = 7'b0000011;
            4'hC: code = 7'b1000110;
            4'hD: code = 7'b0100001;
            4'hE: code = 7'b0000110;
            4'hF: code = 7'b0001110;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pdu_v2_button.sv
// One board button: two-flop synchronizer, counter-based debounce and a
// registered one-cycle pulse on the rising edge of the accepted level.
module pdu_button #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES) + 1;

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] count;
    logic          level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
        end
    end

    // The level flips only after DB_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            level <= 1'b0;
        end else if (sync1 == level) begin
            count <= '0;
        end else if (count == CW'(DB_CYCLES - 1)) begin
            count <= '0;
            level <= sync1;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/pdu_v2.sv
// Processor debug unit: button-driven run/stop/step/reset control of the CPU,
// memory-mapped board IO, and a scanned eight-digit hex display.
module pdu_v2
    import pdu_pkg::*;
#(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int SCAN_BITS  = 17,
    parameter int RST_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        butu,
    input  logic        butd,
    input  logic        butr,
    input  logic        butc,
    input  logic        butl,
    input  logic [15:0] sw,
    output logic        stop,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic [2:0]  seg_sel,
    output logic        pdu_rstn,
    output logic [31:0] pdu_breakpoint,
    output logic        pdu_run,
    input  logic        cpu_stop,
    input  logic [15:0] io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [31:0] chk_if_pc,
    input  logic [31:0] chk_id_pc,
    input  logic [31:0] chk_data,
    output logic [15:0] chk_addr
);

    localparam int RCW = $clog2(RST_CYCLES + 1);

    logic [4:0]           btn_raw;
    logic [4:0]           btn_level;
    logic [4:0]           ev;
    state_t               state;
    state_t               state_next;
    logic [RCW-1:0]       rst_cnt;
    logic [31:0]          disp_reg;
    logic [31:0]          disp_value;
    logic [SCAN_BITS+2:0] scan_cnt;
    logic [2:0]           digit;
    logic                 stop_action;
    logic                 unused_io_rd;

    assign btn_raw = {butu, butd, butr, butc, butl};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        pdu_button #(.DB_CYCLES(DB_CYCLES)) u_btn (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (ev[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= STOP;
        else     state <= state_next;
    end

    // evL wins over everything, so a simultaneous evC cannot restart the CPU.
    always_comb begin
        state_next = state;
        if (ev[BTN_L]) begin
            state_next = STOP;
        end else begin
            unique case (state)
                STOP: begin
                    if (ev[BTN_C])      state_next = RUN;
                    else if (ev[BTN_R]) state_next = STEP;
                end
                RUN:     if (ev[BTN_C] || cpu_stop) state_next = STOP;
                STEP:    state_next = STOP;
                default: state_next = STOP;
            endcase
        end
    end

    assign stop    = (state == STOP);
    assign pdu_run = (state == RUN) || (state == STEP);

    always_ff @(posedge clk) begin
        if (rst)              rst_cnt <= RCW'(RST_CYCLES);
        else if (ev[BTN_L])   rst_cnt <= RCW'(RST_CYCLES);
        else if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
    end

    assign pdu_rstn = ~rst && (rst_cnt == '0);

    assign stop_action = (state == STOP) && !ev[BTN_L];

    always_ff @(posedge clk) begin
        if (rst) begin
            pdu_breakpoint <= 32'hFFFF_FFFF;
            seg_sel        <= SRC_DISP;
        end else if (stop_action) begin
            if (ev[BTN_U]) pdu_breakpoint <= {16'h0, sw};
            if (ev[BTN_D]) seg_sel <= (seg_sel == SRC_BP) ? SRC_DISP : seg_sel + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) chk_addr <= '0;
        else     chk_addr <= sw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= '0;
            disp_reg <= '0;
        end else if (io_we) begin
            if (io_addr == IO_LED) led      <= io_dout[15:0];
            if (io_addr == IO_SEG) disp_reg <= io_dout;
        end
    end

    always_comb begin
        io_din = '0;
        if (io_addr == IO_SW)       io_din = {16'h0, sw};
        else if (io_addr == IO_BTN) io_din = {27'h0, btn_level};
    end

    // Reads have no side effects, so the strobe is intentionally unused.
    assign unused_io_rd = io_rd;

    always_comb begin
        disp_value = disp_reg;
        if (state != RUN) begin
            unique case (seg_sel)
                SRC_IF_PC: disp_value = chk_if_pc;
                SRC_ID_PC: disp_value = chk_id_pc;
                SRC_DATA:  disp_value = chk_data;
                SRC_BP:    disp_value = pdu_breakpoint;
                default:   disp_value = disp_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) scan_cnt <= '0;
        else     scan_cnt <= scan_cnt + 1'b1;
    end

    assign digit = scan_cnt[SCAN_BITS +: 3];
    assign an    = ~(8'h01 << digit);
    assign seg   = hex2seg(disp_value[{digit, 2'b00} +: 4]);

endmodule

// File: tb/tb_pdu_v2.sv
// Directed self-checking bench for pdu_v2 with short debounce and scan periods.
module tb_pdu_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [15:0] sw;
    logic        stop;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic [2:0]  seg_sel;
    logic        pdu_rstn;
    logic [31:0] pdu_breakpoint;
    logic        pdu_run;
    logic        cpu_stop;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;
    logic [31:0] chk_if_pc;
    logic [31:0] chk_id_pc;
    logic [31:0] chk_data;
    logic [15:0] chk_addr;

    int assert_count = 0;
    int fail_count   = 0;

    localparam int U = 4, D = 3, R = 2, C = 1, L = 0;

    always #5 clk = ~clk;

    pdu_v2 #(.DB_CYCLES(4), .SCAN_BITS(2), .RST_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .butu           (btn[U]),
        .butd           (btn[D]),
        .butr           (btn[R]),
        .butc           (btn[C]),
        .butl           (btn[L]),
        .sw             (sw),
        .stop           (stop),
        .led            (led),
        .an             (an),
        .seg            (seg),
        .seg_sel        (seg_sel),
        .pdu_rstn       (pdu_rstn),
        .pdu_breakpoint (pdu_breakpoint),
        .pdu_run        (pdu_run),
        .cpu_stop       (cpu_stop),
        .io_addr        (io_addr),
        .io_dout        (io_dout),
        .io_we          (io_we),
        .io_rd          (io_rd),
        .io_din         (io_din),
        .chk_if_pc      (chk_if_pc),
        .chk_id_pc      (chk_id_pc),
        .chk_data       (chk_data),
        .chk_addr       (chk_addr)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Hold a button well past the debounce window, then release it fully.
    task automatic apply_stimulus(input int idx);
        btn[idx] = 1'b1;
        tick(10);
        btn[idx] = 1'b0;
        tick(10);
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n;
        n = 0;
        while (an !== target && n < 64) begin
            tick(1);
            n++;
        end
        check_output("an_sync", {24'h0, an}, {24'h0, target});
    endtask

    task automatic check_digits(input string tag, input logic [6:0] codes [8]);
        logic [7:0] exp_an;
        wait_an(8'h7F);
        wait_an(8'hFE);
        for (int i = 0; i < 8; i++) begin
            exp_an = ~(8'h01 << i);
            check_output($sformatf("%s_an%0d", tag, i), {24'h0, an}, {24'h0, exp_an});
            check_output($sformatf("%s_seg%0d", tag, i), {25'h0, seg}, {25'h0, codes[i]});
            tick(4);
        end
    endtask

    initial begin
        logic [6:0] codes_bp  [8];
        logic [6:0] codes_reg [8];
        codes_bp  = '{7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000,
                      7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        codes_reg = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011,
                      7'b0100001, 7'b0001000, 7'b0000110, 7'b0100001};

        rst = 1'b1; btn = '0; sw = '0; cpu_stop = 1'b0;
        io_addr = '0; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
        chk_if_pc = 32'h1111_1111; chk_id_pc = 32'h2222_2222; chk_data = 32'h3333_3333;
        tick(2);

        check_output("rst_stop", {31'h0, stop}, 32'd1);
        check_output("rst_run", {31'h0, pdu_run}, 32'd0);
        check_output("rst_bp", pdu_breakpoint, 32'hFFFF_FFFF);
        check_output("rst_led", {16'h0, led}, 32'h0);
        check_output("rst_an", {24'h0, an}, 32'hFE);
        check_output("rst_seg", {25'h0, seg}, 32'h40);
        check_output("rst_seg_sel", {29'h0, seg_sel}, 32'd0);
        check_output("rst_rstn", {31'h0, pdu_rstn}, 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("rstn_low%0d", i), {31'h0, pdu_rstn}, 32'd0);
            tick(1);
        end
        check_output("rstn_high", {31'h0, pdu_rstn}, 32'd1);

        $display("[TB] run via centre button, stop via cpu_stop");
        btn[C] = 1'b1;
        tick(7);
        check_output("c_latency_stop", {31'h0, stop}, 32'd1);
        tick(1);
        check_output("c_run", {31'h0, pdu_run}, 32'd1);
        check_output("c_stop", {31'h0, stop}, 32'd0);
        tick(2);
        btn[C] = 1'b0;
        tick(10);
        check_output("c_still_run", {31'h0, pdu_run}, 32'd1);
        cpu_stop = 1'b1;
        tick(1);
        cpu_stop = 1'b0;
        check_output("cpu_stop_run", {31'h0, pdu_run}, 32'd0);
        check_output("cpu_stop_stop", {31'h0, stop}, 32'd1);

        $display("[TB] single step");
        btn[R] = 1'b1;
        tick(7);
        check_output("step_before", {31'h0, pdu_run}, 32'd0);
        tick(1);
        check_output("step_run", {31'h0, pdu_run}, 32'd1);
        tick(1);
        check_output("step_after_run", {31'h0, pdu_run}, 32'd0);
        check_output("step_after_stop", {31'h0, stop}, 32'd1);
        tick(1);
        btn[R] = 1'b0;
        tick(10);

        $display("[TB] breakpoint and display source");
        sw = 16'h0123;
        apply_stimulus(U);
        check_output("bp_set", pdu_breakpoint, 32'h0000_0123);
        check_output("chk_addr", {16'h0, chk_addr}, 32'h0123);
        repeat (4) apply_stimulus(D);
        check_output("seg_sel4", {29'h0, seg_sel}, 32'd4);
        check_digits("bp", codes_bp);

        $display("[TB] IO bus");
        io_addr = 16'h0000; io_dout = 32'h0000_A5A5; io_we = 1'b1;
        tick(1);
        io_addr = 16'h0010; io_dout = 32'h0000_1234;
        tick(1);
        io_we = 1'b0;
        check_output("led_write", {16'h0, led}, 32'hA5A5);
        io_addr = 16'h0008; io_dout = 32'hDEAD_BEEF; io_we = 1'b1;
        tick(1);
        io_we = 1'b0;
        sw = 16'h00F0; io_addr = 16'h0004; io_rd = 1'b1;
        #1;
        check_output("rd_sw", io_din, 32'h0000_00F0);
        io_addr = 16'h0020;
        #1;
        check_output("rd_other", io_din, 32'h0);
        io_addr = 16'h000C;
        btn[U] = 1'b1;
        tick(6);
        check_output("rd_btn_u", io_din, 32'h0000_0010);
        btn[U] = 1'b0;
        tick(10);
        check_output("rd_btn_idle", io_din, 32'h0);
        check_output("bp_from_u", pdu_breakpoint, 32'h0000_00F0);
        io_rd = 1'b0;

        apply_stimulus(D);
        check_output("seg_sel_wrap", {29'h0, seg_sel}, 32'd0);
        check_digits("disp", codes_reg);

        $display("[TB] left button during run with concurrent centre");
        apply_stimulus(C);
        check_output("l_pre_run", {31'h0, pdu_run}, 32'd1);
        btn[L] = 1'b1;
        btn[C] = 1'b1;
        tick(7);
        check_output("l_before", {31'h0, stop}, 32'd0);
        tick(1);
        check_output("l_stop", {31'h0, stop}, 32'd1);
        check_output("l_run", {31'h0, pdu_run}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("l_rstn_low%0d", i), {31'h0, pdu_rstn}, 32'd0);
            tick(1);
        end
        check_output("l_rstn_high", {31'h0, pdu_rstn}, 32'd1);
        btn[L] = 1'b0;
        btn[C] = 1'b0;
        tick(10);
        check_output("l_c_ignored", {31'h0, stop}, 32'd1);

        $display("[TB] reset mid-run");
        apply_stimulus(C);
        check_output("mid_pre_run", {31'h0, pdu_run}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_output("mid_stop", {31'h0, stop}, 32'd1);
        check_output("mid_led", {16'h0, led}, 32'h0);
        check_output("mid_bp", pdu_breakpoint, 32'hFFFF_FFFF);
        check_output("mid_an", {24'h0, an}, 32'hFE);
        check_output("mid_seg", {25'h0, seg}, 32'h40);
        rst = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
